// File: rtl/writeback_stage.sv
// EX->WB pipeline register with HI/LO, GPIO output and result select.
// Optional WB->EX operand forwarding enabled by defining WB_BYPASS_EN.
module writeback_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_EX,
  input  logic        regwrite_EX,
  input  logic        enhilo_EX,
  input  logic [1:0]  regsel_EX,
  input  logic        rdrt_EX,
  input  logic        gpio_out_en_EX,
  input  logic [4:0]  rd_addr_EX,
  input  logic [4:0]  rt_addr_EX,
  input  logic [4:0]  rs_addr_EX,
  input  logic [31:0] alu_lo_EX,
  input  logic [31:0] alu_hi_EX,
  input  logic [31:0] rf_rs_data,
  input  logic [31:0] rf_rt_data,
  output logic [31:0] rs_data_EX,
  output logic [31:0] rt_data_EX,
  output logic        regwrite_WB,
  output logic [4:0]  writeaddr_WB,
  output logic [31:0] writedata_WB,
  output logic [31:0] hi_WB,
  output logic [31:0] lo_WB,
  output logic [31:0] GPIO_OUT
);

  logic [4:0]  dest;
  logic [31:0] wdata_nxt;
  logic        rw_nxt;
  logic        hilo_ld;
  logic        gpio_ld;

  assign dest    = rdrt_EX ? rt_addr_EX : rd_addr_EX;
  assign rw_nxt  = valid_EX & regwrite_EX & (dest != 5'd0);
  assign hilo_ld = valid_EX & enhilo_EX;
  assign gpio_ld = valid_EX & gpio_out_en_EX;

  // mfhi/mflo read the registers as they stand before this edge
  always_comb begin
    wdata_nxt = alu_lo_EX;
    unique case (regsel_EX)
      2'd1:    wdata_nxt = hi_WB;
      2'd2:    wdata_nxt = lo_WB;
      default: wdata_nxt = alu_lo_EX;
    endcase
  end

`ifdef WB_BYPASS_EN
  always_comb begin
    rs_data_EX = rf_rs_data;
    rt_data_EX = rf_rt_data;
    if (regwrite_WB && (writeaddr_WB == rs_addr_EX))
      rs_data_EX = writedata_WB;
    if (regwrite_WB && (writeaddr_WB == rt_addr_EX))
      rt_data_EX = writedata_WB;
  end
`else
  logic unused_rs;
  assign unused_rs  = ^rs_addr_EX;
  assign rs_data_EX = rf_rs_data;
  assign rt_data_EX = rf_rt_data;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regwrite_WB  <= 1'b0;
      writeaddr_WB <= 5'd0;
      writedata_WB <= 32'd0;
      hi_WB        <= 32'd0;
      lo_WB        <= 32'd0;
      GPIO_OUT     <= 32'd0;
    end else begin
      regwrite_WB  <= rw_nxt;
      writeaddr_WB <= dest;
      writedata_WB <= wdata_nxt;
      if (hilo_ld) begin
        hi_WB <= alu_hi_EX;
        lo_WB <= alu_lo_EX;
      end
      if (gpio_ld)
        GPIO_OUT <= rt_data_EX;
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed plus random bench for writeback_stage against a rule-level model.
// Works with or without WB_BYPASS_EN.
module tb_writeback_stage;

  logic        clk;
  logic        rst;
  logic        valid_EX;
  logic        regwrite_EX;
  logic        enhilo_EX;
  logic [1:0]  regsel_EX;
  logic        rdrt_EX;
  logic        gpio_out_en_EX;
  logic [4:0]  rd_addr_EX;
  logic [4:0]  rt_addr_EX;
  logic [4:0]  rs_addr_EX;
  logic [31:0] alu_lo_EX;
  logic [31:0] alu_hi_EX;
  logic [31:0] rf_rs_data;
  logic [31:0] rf_rt_data;
  logic [31:0] rs_data_EX;
  logic [31:0] rt_data_EX;
  logic        regwrite_WB;
  logic [4:0]  writeaddr_WB;
  logic [31:0] writedata_WB;
  logic [31:0] hi_WB;
  logic [31:0] lo_WB;
  logic [31:0] GPIO_OUT;

  int checks;
  int failures;

  logic        m_rw;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [31:0] m_gpio;

  writeback_stage dut (
    .clk(clk), .rst(rst),
    .valid_EX(valid_EX), .regwrite_EX(regwrite_EX),
    .enhilo_EX(enhilo_EX), .regsel_EX(regsel_EX),
    .rdrt_EX(rdrt_EX), .gpio_out_en_EX(gpio_out_en_EX),
    .rd_addr_EX(rd_addr_EX), .rt_addr_EX(rt_addr_EX),
    .rs_addr_EX(rs_addr_EX), .alu_lo_EX(alu_lo_EX),
    .alu_hi_EX(alu_hi_EX), .rf_rs_data(rf_rs_data),
    .rf_rt_data(rf_rt_data), .rs_data_EX(rs_data_EX),
    .rt_data_EX(rt_data_EX), .regwrite_WB(regwrite_WB),
    .writeaddr_WB(writeaddr_WB), .writedata_WB(writedata_WB),
    .hi_WB(hi_WB), .lo_WB(lo_WB), .GPIO_OUT(GPIO_OUT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] a,
                                      input logic [31:0] rf);
`ifdef WB_BYPASS_EN
    if (m_rw && m_wa == a) return m_wd;
`endif
    return rf;
  endfunction

  task automatic chk_outs(input string tag);
    chk({tag, ".rw"},   {31'd0, regwrite_WB}, {31'd0, m_rw});
    chk({tag, ".wa"},   {27'd0, writeaddr_WB}, {27'd0, m_wa});
    chk({tag, ".wd"},   writedata_WB, m_wd);
    chk({tag, ".hi"},   hi_WB, m_hi);
    chk({tag, ".lo"},   lo_WB, m_lo);
    chk({tag, ".gpio"}, GPIO_OUT, m_gpio);
  endtask

  task automatic model_reset();
    m_rw = 0; m_wa = 0; m_wd = 0;
    m_hi = 0; m_lo = 0; m_gpio = 0;
  endtask

  // Apply current inputs for one cycle; check operands, then the WB state
  task automatic tick(input string tag);
    logic [4:0]  dst;
    logic [31:0] ers, ert, nwd;
    #1;
    ers = fwd(rs_addr_EX, rf_rs_data);
    ert = fwd(rt_addr_EX, rf_rt_data);
    chk({tag, ".rs_op"}, rs_data_EX, ers);
    chk({tag, ".rt_op"}, rt_data_EX, ert);
    dst = rdrt_EX ? rt_addr_EX : rd_addr_EX;
    if (regsel_EX == 2'd1)      nwd = m_hi;
    else if (regsel_EX == 2'd2) nwd = m_lo;
    else                        nwd = alu_lo_EX;
    @(posedge clk);
    m_rw = valid_EX && regwrite_EX && dst != 0;
    m_wa = dst;
    m_wd = nwd;
    if (valid_EX && enhilo_EX) begin
      m_hi = alu_hi_EX;
      m_lo = alu_lo_EX;
    end
    if (valid_EX && gpio_out_en_EX) m_gpio = ert;
    #1;
    chk_outs(tag);
  endtask

  task automatic idle();
    valid_EX = 0; regwrite_EX = 0; enhilo_EX = 0;
    regsel_EX = 0; rdrt_EX = 0; gpio_out_en_EX = 0;
    rd_addr_EX = 0; rt_addr_EX = 0; rs_addr_EX = 0;
    alu_lo_EX = 0; alu_hi_EX = 0;
    rf_rs_data = 0; rf_rt_data = 0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] v);
    idle();
    valid_EX = 1; regwrite_EX = 1;
    rd_addr_EX = rd; alu_lo_EX = v;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    idle();
    model_reset();
    rst = 0;
    #2;
    chk_outs("reset");
    @(negedge clk);
    rst = 1;

    alu(5'd5, 32'h7);
    tick("addu");
    chk("addu.wd7", writedata_WB, 32'h7);

    idle();
    valid_EX = 1; enhilo_EX = 1;
    alu_hi_EX = 32'h1; alu_lo_EX = 32'hFFFF_FFFE;
    tick("multu");
    alu(5'd3, 32'h0); regsel_EX = 2'd1;
    tick("mfhi");
    chk("mfhi.val", writedata_WB, 32'h1);
    alu(5'd4, 32'h0); regsel_EX = 2'd2;
    tick("mflo");
    chk("mflo.val", writedata_WB, 32'hFFFF_FFFE);

    alu(5'd9, 32'h55);
    rdrt_EX = 1; rt_addr_EX = 5'd0;
    tick("addi_r0");
    chk("addi_r0.rw", {31'd0, regwrite_WB}, 32'd0);

    idle();
    valid_EX = 1; gpio_out_en_EX = 1;
    rt_addr_EX = 5'd20; rf_rt_data = 32'hDEAD_BEEF;
    tick("gpio");
    chk("gpio.val", GPIO_OUT, 32'hDEAD_BEEF);
    valid_EX = 0; rf_rt_data = 32'h1;
    tick("gpio_bubble");
    chk("gpio_hold", GPIO_OUT, 32'hDEAD_BEEF);

    alu(5'd8, 32'h1234);
    tick("wr_r8");
    idle();
    rs_addr_EX = 5'd8; rf_rs_data = 32'h0;
    #1;
`ifdef WB_BYPASS_EN
    chk("bypass_rs", rs_data_EX, 32'h1234);
`else
    chk("bypass_rs", rs_data_EX, 32'h0);
`endif
    tick("after_r8");

    repeat (300) begin
      valid_EX       = ($urandom_range(0, 3) != 0);
      regwrite_EX    = $urandom_range(0, 1);
      enhilo_EX      = ($urandom_range(0, 3) == 0);
      regsel_EX      = 2'($urandom_range(0, 3));
      rdrt_EX        = $urandom_range(0, 1);
      gpio_out_en_EX = ($urandom_range(0, 3) == 0);
      rd_addr_EX     = 5'($urandom_range(0, 7));
      rt_addr_EX     = 5'($urandom_range(0, 7));
      rs_addr_EX     = 5'($urandom_range(0, 7));
      alu_lo_EX      = $urandom;
      alu_hi_EX      = $urandom;
      rf_rs_data     = $urandom;
      rf_rt_data     = $urandom;
      tick("rand");
    end

    idle();
    valid_EX = 1; enhilo_EX = 1;
    alu_hi_EX = 32'hA; alu_lo_EX = 32'h3;
    tick("pre_rst_mult");
    idle();
    valid_EX = 1; gpio_out_en_EX = 1; rf_rt_data = 32'hB;
    tick("pre_rst_gpio");
    alu(5'd6, 32'h99);
    #2;
    rst = 0;
    model_reset();
    #1;
    chk_outs("async_rst");
    @(posedge clk);
    #1;
    chk_outs("rst_hold");
    @(negedge clk);
    rst = 1;
    alu(5'd7, 32'h42);
    tick("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have these ports, one per line (name, direction, width, meaning); clock and reset first; one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- valid_EX  in  1  EX instruction is live; 0 = bubble.
- regwrite_EX  in  1  EX instruction writes the register file.
- enhilo_EX  in  1  mult/multu: load HI/LO.
- regsel_EX  in  2  result select: 0 ALU, 1 mfhi, 2 mflo, 3 ALU.
- rdrt_EX  in  1  destination select: 1 = rt, 0 = rd.
- gpio_out_en_EX  in  1  GPIO write (srl, shamt 0).
- rd_addr_EX  in  5  rd field.
- rt_addr_EX  in  5  rt field.
- rs_addr_EX  in  5  rs field.
- alu_lo_EX  in  32  ALU result, or low word of the product.
- alu_hi_EX  in  32  high word of the product.
- rf_rs_data  in  32  register-file rs read data.
- rf_rt_data  in  32  register-file rt read data.
- rs_data_EX  out  32  rs operand to ALU.
- rt_data_EX  out  32  rt operand to ALU.
- regwrite_WB  out  1  register-file write enable.
- writeaddr_WB  out  5  register-file write address.
- writedata_WB  out  32  register-file write data.
- hi_WB  out  32  HI register.
- lo_WB  out  32  LO register.
- GPIO_OUT  out  32  GPIO output register.

Function
REQ-002 SHALL treat an EX instruction as live only when valid_EX=1; when valid_EX=0, regwrite, enhilo and gpio_out_en SHALL be ignored at that edge.
REQ-003 On each rising clk, SHALL set regwrite_WB <= valid_EX & regwrite_EX & (dest != 0), where dest = rdrt_EX ? rt_addr_EX : rd_addr_EX.
REQ-004 SHALL load writeaddr_WB <= dest at every edge, regardless of regwrite.
REQ-005 SHALL load writedata_WB according to regsel_EX: alu_lo_EX (0 or 3), current hi_WB (1), current lo_WB (2); the value is sampled before that same edge's HI/LO update.
REQ-006 SHALL load hi_WB <= alu_hi_EX and lo_WB <= alu_lo_EX on an edge with a live enhilo_EX; otherwise HI/LO hold.
REQ-007 SHALL give one-cycle latency from EX to WB; mfhi/mflo issued in the cycle directly after mult SHALL return the new product, with no stall.
REQ-008 SHALL load GPIO_OUT <= rt_data_EX on an edge with a live gpio_out_en_EX; otherwise GPIO_OUT holds.
REQ-009 SHALL never assert regwrite_WB for address 0; a write to $0 becomes a no-op write.
REQ-010 SHALL process each live instruction independently; no internal stall and no back-pressure.

Reset
REQ-011 While rst=0, SHALL asynchronously clear regwrite_WB, writeaddr_WB, writedata_WB, hi_WB, lo_WB and GPIO_OUT to 0.
REQ-012 SHALL drop any instruction in flight at reset assertion; after deassertion the first edge behaves per REQ-002 to REQ-010.

Configuration
REQ-013 With WB_BYPASS_EN defined, SHALL drive rs_data_EX = writedata_WB when regwrite_WB=1 and writeaddr_WB == rs_addr_EX, else rf_rs_data; rt_data_EX SHALL follow the same rule on rt_addr_EX; both paths are combinational.
REQ-014 With WB_BYPASS_EN undefined, SHALL drive rs_data_EX = rf_rs_data and rt_data_EX = rf_rt_data; the register file must then be write-through.

Verification
REQ-015 addu, rd=5, alu_lo_EX=0x0000_0007 -> next cycle: regwrite_WB=1, writeaddr_WB=5, writedata_WB=7.
REQ-016 multu with alu_hi_EX=0x1, alu_lo_EX=0xFFFF_FFFE, then mfhi rd=3, then mflo rd=4 -> writes of 0x1 to r3, then 0xFFFF_FFFE to r4.
REQ-017 addi, rdrt_EX=1, rt=0, alu_lo_EX=0x55 -> regwrite_WB=0; writeaddr_WB=0.
REQ-018 srl gpio with rf_rt_data=0xDEAD_BEEF, valid_EX=1 -> GPIO_OUT=0xDEAD_BEEF; repeating with valid_EX=0 and rf_rt_data=0x1 -> GPIO_OUT unchanged.
REQ-019 WB_BYPASS_EN defined: r8 written with 0x1234, next instruction rs=8, rf_rs_data=0 -> rs_data_EX=0x1234; undefined -> rs_data_EX=0.
REQ-020 rst driven low mid-cycle while hi_WB=0xA and GPIO_OUT=0xB -> all outputs 0 immediately, before the next clk edge.
